// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives memory handshakes and datapath strobes.
//
// state  | meaning
// IDLE   | post-reset, one cycle, checks for debug halt
// FETCH  | instruction memory request, IR loaded on ready
// DECODE | decode settles
// EXEC   | ALU cycle, selects memory or writeback path
// MEM    | data memory access
// WB     | register/PC write, retirement
// HALT   | debug halt, no requests
// ERR    | memory timeout, held until reset
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             jal,
    input  logic             jalr,
    input  logic             br_taken,
    input  logic             halt_req,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] to_cnt;
    logic            mem_wait;
    logic            to_expired;
    logic            enter_wait_state;

    // A wait cycle is any FETCH/MEM cycle whose memory has not answered yet.
    assign mem_wait   = ((state_q == FETCH) && !imem_ready) ||
                        ((state_q == MEM)   && !dmem_ready);
    assign to_expired = mem_wait && (to_cnt == TO_LAST);

    assign enter_wait_state = (state_d != state_q) &&
                              ((state_d == FETCH) || (state_d == MEM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (enter_wait_state) begin
            to_cnt <= '0;
        end else if (mem_wait) begin
            to_cnt <= to_cnt + TO_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (state_q == WB) begin
            retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = halt_req ? HALT : FETCH;
            FETCH: begin
                if (imem_ready) begin
                    state_d = DECODE;
                end else if (to_expired) begin
                    state_d = ERR;
                end
            end
            DECODE: state_d = EXEC;
            EXEC:   state_d = (MemRead || MemWrite) ? MEM : WB;
            MEM: begin
                if (dmem_ready) begin
                    state_d = WB;
                end else if (to_expired) begin
                    state_d = ERR;
                end
            end
            WB:     state_d = halt_req ? HALT : FETCH;
            HALT: begin
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            ERR:    state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        retire   = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
            end
            WB: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                rf_we  = RegWrite;
                // jalr outranks jal when a bad decode asserts both.
                if (jalr) begin
                    pc_sel = 2'd2;
                end else if (jal || br_taken) begin
                    pc_sel = 2'd1;
                end
            end
            HALT: halted = 1'b1;
            ERR:  err    = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks instruction classes, memory waits,
// timeouts, debug halt and mid-access reset with hand-derived expectations.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready, dmem_ready;
    logic        MemRead, MemWrite, RegWrite;
    logic        jal, jalr, br_taken, halt_req;
    logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
    logic [1:0]  pc_sel;
    logic        retire;
    logic [31:0] retire_cnt;
    logic [2:0]  state;
    logic        halted, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .MEM_TIMEOUT(4),
        .TO_W       (3),
        .CNT_W      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .jal       (jal),
        .jalr      (jalr),
        .br_taken  (br_taken),
        .halt_req  (halt_req),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .ir_we     (ir_we),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .retire    (retire),
        .retire_cnt(retire_cnt),
        .state     (state),
        .halted    (halted),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample midway between active edges.
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Non-memory instruction starting in FETCH with imem_ready high.
    task automatic run_alu(input string tag, input logic [1:0] sel);
        tick; check({tag, " decode"}, 32'(state), 32'd2);
        tick; check({tag, " exec"},   32'(state), 32'd3);
        tick; check({tag, " wb"},     32'(state), 32'd5);
        check({tag, " pc_sel"}, 32'(pc_sel), 32'(sel));
        check({tag, " retire"}, 32'(retire), 32'd1);
        tick; check({tag, " fetch"},  32'(state), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        jal = 1'b0; jalr = 1'b0; br_taken = 1'b0; halt_req = 1'b0;

        // reset and a plain ALU instruction
        tick; tick;
        check("rst state", 32'(state), 32'd0);
        check("rst cnt", retire_cnt, 32'd0);
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst pc_we", 32'(pc_we), 32'd0);
        rst_n = 1'b1; imem_ready = 1'b1; RegWrite = 1'b1; settle;
        check("idle state", 32'(state), 32'd0);
        tick;
        check("add fetch", 32'(state), 32'd1);
        check("add imem_req", 32'(imem_req), 32'd1);
        check("add ir_we", 32'(ir_we), 32'd1);
        check("add fetch pc_we", 32'(pc_we), 32'd0);
        tick; check("add decode", 32'(state), 32'd2);
        check("add decode rf_we", 32'(rf_we), 32'd0);
        tick; check("add exec", 32'(state), 32'd3);
        check("add exec retire", 32'(retire), 32'd0);
        tick; check("add wb", 32'(state), 32'd5);
        check("add rf_we", 32'(rf_we), 32'd1);
        check("add pc_we", 32'(pc_we), 32'd1);
        check("add retire", 32'(retire), 32'd1);
        check("add pc_sel", 32'(pc_sel), 32'd0);
        check("add cnt wb", retire_cnt, 32'd0);
        tick; check("add next fetch", 32'(state), 32'd1);
        check("add cnt", retire_cnt, 32'd1);
        check("add post rf_we", 32'(rf_we), 32'd0);

        // load with two data wait cycles
        MemRead = 1'b1; dmem_ready = 1'b0; settle;
        tick; check("lw decode", 32'(state), 32'd2);
        tick; check("lw exec", 32'(state), 32'd3);
        tick; check("lw mem1", 32'(state), 32'd4);
        check("lw dmem_req1", 32'(dmem_req), 32'd1);
        check("lw dmem_we", 32'(dmem_we), 32'd0);
        tick; check("lw dmem_req2", 32'(dmem_req), 32'd1);
        tick; dmem_ready = 1'b1; settle;
        check("lw mem3", 32'(state), 32'd4);
        check("lw dmem_req3", 32'(dmem_req), 32'd1);
        tick; check("lw wb", 32'(state), 32'd5);
        check("lw rf_we", 32'(rf_we), 32'd1);
        check("lw wb dmem_req", 32'(dmem_req), 32'd0);
        tick; check("lw cnt", retire_cnt, 32'd2);

        // store with two data wait cycles
        MemRead = 1'b0; MemWrite = 1'b1; RegWrite = 1'b0; dmem_ready = 1'b0; settle;
        tick; tick;
        tick; check("sw mem1", 32'(state), 32'd4);
        check("sw dmem_we", 32'(dmem_we), 32'd1);
        tick; check("sw mem2", 32'(state), 32'd4);
        tick; dmem_ready = 1'b1; settle;
        check("sw mem3", 32'(dmem_req), 32'd1);
        tick; check("sw wb", 32'(state), 32'd5);
        check("sw rf_we", 32'(rf_we), 32'd0);
        check("sw pc_we", 32'(pc_we), 32'd1);
        tick; check("sw cnt", retire_cnt, 32'd3);

        // next-PC select priority
        MemWrite = 1'b0; jal = 1'b1; jalr = 1'b1; settle;
        run_alu("jal+jalr", 2'd2);
        jal = 1'b0; jalr = 1'b0; br_taken = 1'b1; settle;
        run_alu("branch", 2'd1);
        br_taken = 1'b0; jal = 1'b1; settle;
        run_alu("jal", 2'd1);
        jal = 1'b0; settle;
        run_alu("seq", 2'd0);
        check("pc cnt", retire_cnt, 32'd7);

        // timeout in MEM; a prior FETCH wait must not shorten the MEM budget
        imem_ready = 1'b0; settle;
        tick; check("fwait state", 32'(state), 32'd1);
        imem_ready = 1'b1; MemWrite = 1'b1; dmem_ready = 1'b0; settle;
        check("fwait ir_we", 32'(ir_we), 32'd1);
        tick; tick;
        tick; check("mto mem1", 32'(dmem_req), 32'd1);
        tick; check("mto mem2", 32'(dmem_req), 32'd1);
        tick; check("mto mem3", 32'(dmem_req), 32'd1);
        tick; check("mto mem4", 32'(state), 32'd4);
        tick; check("mto err state", 32'(state), 32'd7);
        check("mto err", 32'(err), 32'd1);
        check("mto dmem_req", 32'(dmem_req), 32'd0);
        rst_n = 1'b0; MemWrite = 1'b0; settle;
        tick; check("mto rst state", 32'(state), 32'd0);
        check("mto rst err", 32'(err), 32'd0);
        check("mto rst cnt", retire_cnt, 32'd0);

        // timeout in FETCH
        rst_n = 1'b1; imem_ready = 1'b0; settle;
        tick; check("fto req1", 32'(imem_req), 32'd1);
        tick; check("fto req2", 32'(imem_req), 32'd1);
        tick; check("fto req3", 32'(imem_req), 32'd1);
        tick; check("fto req4", 32'(imem_req), 32'd1);
        tick; check("fto err state", 32'(state), 32'd7);
        check("fto err", 32'(err), 32'd1);
        check("fto imem_req", 32'(imem_req), 32'd0);
        tick; tick; check("fto sticky", 32'(err), 32'd1);
        rst_n = 1'b0; settle;
        tick; check("fto rst", 32'(state), 32'd0);

        // ready on the last allowed cycle avoids the error
        rst_n = 1'b1; settle;
        tick; tick; tick;
        tick; imem_ready = 1'b1; settle;
        check("edge ir_we", 32'(ir_we), 32'd1);
        tick; check("edge decode", 32'(state), 32'd2);
        check("edge err", 32'(err), 32'd0);

        // halt raised mid-instruction lets it retire first
        tick; check("halt exec", 32'(state), 32'd3);
        halt_req = 1'b1; settle;
        tick; check("halt wb", 32'(state), 32'd5);
        check("halt retire", 32'(retire), 32'd1);
        tick; check("halt state", 32'(state), 32'd6);
        check("halted", 32'(halted), 32'd1);
        check("halt imem_req", 32'(imem_req), 32'd0);
        tick; check("halt hold", 32'(state), 32'd6);
        halt_req = 1'b0; settle;
        tick; check("halt resume", 32'(state), 32'd1);
        check("halt released", 32'(halted), 32'd0);
        check("halt cnt", retire_cnt, 32'd1);

        // reset during a data wait aborts the access
        MemRead = 1'b1; dmem_ready = 1'b0; settle;
        tick; tick; tick;
        tick; check("abort mem", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; settle;
        tick; check("abort state", 32'(state), 32'd0);
        check("abort dmem_req", 32'(dmem_req), 32'd0);
        check("abort retire", 32'(retire), 32'd0);
        check("abort cnt", retire_cnt, 32'd0);

        // halt requested straight out of IDLE
        MemRead = 1'b0; halt_req = 1'b1; rst_n = 1'b1; settle;
        tick; check("idle halt", 32'(state), 32'd6);
        halt_req = 1'b0; settle;
        tick; check("idle resume", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
